// File: rtl/spi_master_if.sv
// Host handshake and SPI pin bundle for spi_master.
interface spi_master_if;
  logic       start;
  logic [7:0] cmd;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;

  modport master (
    input  start, cmd, wdata, miso,
    output busy, done, rdata, sclk, cs_n, mosi
  );

  modport slave (
    output start, cmd, wdata, miso,
    input  busy, done, rdata, sclk, cs_n, mosi
  );
endinterface

// File: rtl/spi_master.sv
// Mode-0 SPI master running one command byte + data byte transaction per start.
// Every bit (including the last) spends CLK_DIV cycles with sclk high and
// CLK_DIV cycles with sclk low, so chip select stays low for 34*CLK_DIV cycles:
// SETUP + 16 full bits + HOLD. After the final high phase the master takes one
// more low phase (shift register already empty, so mosi is 0), with the bit
// counter pinned at 15, before the HOLD phase.
module spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.master bus
);

  localparam int unsigned PHASE_W = 8;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned SHIFT_W = 16;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = '1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_t;

  state_t              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                tail_q, tail_d;
  logic                rd_q, rd_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic [BYTE_W-1:0]   rshift_q, rshift_d;
  logic [BYTE_W-1:0]   rdata_q, rdata_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                phase_done;

  assign phase_done = (phase_q == '0);

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      bit_q    <= '0;
      tail_q   <= 1'b0;
      rd_q     <= 1'b0;
      shift_q  <= '0;
      rshift_q <= '0;
      rdata_q  <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      tail_q   <= tail_d;
      rd_q     <= rd_d;
      shift_q  <= shift_d;
      rshift_q <= rshift_d;
      rdata_q  <= rdata_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; outputs are computed one cycle ahead and registered.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_done ? PHASE_LAST : phase_q - PHASE_W'(1);
    bit_d    = bit_q;
    tail_d   = tail_q;
    rd_d     = rd_q;
    shift_d  = shift_q;
    rshift_d = rshift_q;
    rdata_d  = rdata_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    mosi_d   = mosi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        phase_d = PHASE_LAST;
        if (bus.start) begin
          state_d  = SETUP;
          rd_d     = bus.cmd[7];
          shift_d  = {bus.cmd, (bus.cmd[7] ? 8'h00 : bus.wdata)};
          bit_d    = '0;
          tail_d   = 1'b0;
          rshift_d = '0;
          cs_n_d   = 1'b0;
          mosi_d   = bus.cmd[7];
          busy_d   = 1'b1;
        end
      end
      SETUP: begin
        if (phase_done) begin
          state_d = HIGH;
          sclk_d  = 1'b1;
        end
      end
      HIGH: begin
        if (phase_done) begin
          state_d = LOW;
          sclk_d  = 1'b0;
          shift_d = shift_q << 1;
          mosi_d  = shift_q[SHIFT_W-2];
          if (bit_q == BIT_LAST) begin
            tail_d = 1'b1;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      LOW: begin
        if (phase_done) begin
          if (tail_q) begin
            state_d = HOLD;
            mosi_d  = 1'b0;
          end else begin
            state_d = HIGH;
            sclk_d  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (phase_done) begin
          state_d = GAP;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          if (rd_q) begin
            rdata_d = rshift_q;
          end
        end
      end
      GAP: begin
        if (phase_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Read data bits 8..15 are captured on the edge that raises sclk.
    if (state_d == HIGH && state_q != HIGH && rd_q && bit_q[3]) begin
      rshift_d[bit_q[2:0]] = bus.miso;
    end
  end

  assign bus.sclk  = sclk_q;
  assign bus.cs_n  = cs_n_q;
  assign bus.mosi  = mosi_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: one instance with CLK_DIV=4, one with CLK_DIV=1.
module tb_spi_master;

  logic       clk;
  logic       rst_n;
  logic       sel;          // 0: CLK_DIV=4 instance, 1: CLK_DIV=1 instance
  logic       start_r;
  logic [7:0] cmd_r;
  logic [7:0] wdata_r;
  logic       miso_r;

  spi_master_if if4 ();
  spi_master_if if1 ();

  assign if4.start = start_r & ~sel;
  assign if1.start = start_r & sel;
  assign if4.cmd   = cmd_r;
  assign if1.cmd   = cmd_r;
  assign if4.wdata = wdata_r;
  assign if1.wdata = wdata_r;
  assign if4.miso  = miso_r;
  assign if1.miso  = miso_r;

  spi_master #(.CLK_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  spi_master #(.CLK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic       o_sclk, o_cs_n, o_mosi, o_busy, o_done;
  logic [7:0] o_rdata;
  assign o_sclk  = sel ? if1.sclk  : if4.sclk;
  assign o_cs_n  = sel ? if1.cs_n  : if4.cs_n;
  assign o_mosi  = sel ? if1.mosi  : if4.mosi;
  assign o_busy  = sel ? if1.busy  : if4.busy;
  assign o_done  = sel ? if1.done  : if4.done;
  assign o_rdata = sel ? if1.rdata : if4.rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave / monitor state
  logic [7:0]  slave_byte = 8'h00;
  logic [15:0] mosi_cap   = 16'h0000;
  int rises = 0, cs_lo_cnt = 0, cs_hi_len = 0, last_gap = 0;
  int hi_len = 0, lo_len = 0, sclk_err = 0, mosi_err = 0, done_err = 0, done_cnt = 0;
  logic prev_sclk = 1'b0, prev_cs_n = 1'b1, prev_mosi = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Bus monitor and SPI slave model: samples mosi on sclk rises, returns slave_byte LSB first.
  always @(negedge clk) begin
    int d;
    d = sel ? 1 : 4;
    if (!o_cs_n) begin
      if (prev_cs_n) begin
        cs_lo_cnt = 1;
        rises     = 0;
        last_gap  = cs_hi_len;
      end else begin
        cs_lo_cnt++;
      end
    end else begin
      if (!prev_cs_n) cs_hi_len = 1;
      else            cs_hi_len++;
    end
    if (o_sclk && !prev_sclk) begin
      if (rises > 0 && lo_len != d) sclk_err++;
      rises++;
      mosi_cap = {mosi_cap[14:0], o_mosi};
      hi_len   = 1;
    end else if (o_sclk) begin
      hi_len++;
    end else if (prev_sclk) begin
      if (hi_len != d) sclk_err++;
      lo_len = 1;
    end else begin
      lo_len++;
    end
    if (!o_cs_n && !prev_cs_n && (o_mosi != prev_mosi) && !(prev_sclk && !o_sclk)) mosi_err++;
    if (o_done) begin
      done_cnt++;
      if (!(o_cs_n && !prev_cs_n)) done_err++;
    end
    miso_r    = (rises >= 8 && rises < 16) ? slave_byte[3'(rises - 8)] : 1'b0;
    prev_sclk = o_sclk;
    prev_cs_n = o_cs_n;
    prev_mosi = o_mosi;
  end

  // One full transaction; returns in the first cycle busy is low again.
  task automatic run_txn(input logic [7:0] c, input logic [7:0] w, input logic [7:0] sb,
                         input logic [15:0] exp_mosi, input logic [7:0] exp_rd,
                         input bit b2b, input bit hold);
    int d, n, limit;
    d     = sel ? 1 : 4;
    limit = 40 * d + 10;
    slave_byte = sb;
    cmd_r      = c;
    wdata_r    = w;
    start_r    = 1'b1;
    sclk_err = 0; mosi_err = 0; done_err = 0; done_cnt = 0;
    tick();
    n = 1;
    chk("busy_rise", 32'(o_busy), 32'd1);
    chk("cs_fall", 32'(o_cs_n), 32'd0);
    chk("mosi_first", 32'(o_mosi), 32'(c[7]));
    if (b2b) chk("cs_gap_min", 32'(last_gap >= d + 1), 32'd1);
    if (hold) begin
      cmd_r   = ~c;
      wdata_r = ~w;
    end else begin
      start_r = 1'b0;
    end
    while (!o_done && n < limit) begin
      tick();
      n++;
    end
    chk("done_latency", 32'(n), 32'(34 * d + 1));
    chk("rdata", 32'(o_rdata), 32'(exp_rd));
    chk("mosi_bits", 32'(mosi_cap), 32'(exp_mosi));
    chk("sclk_rises", 32'(rises), 32'd16);
    chk("cs_low_len", 32'(cs_lo_cnt), 32'(34 * d));
    while (o_busy && n < limit) begin
      tick();
      n++;
    end
    chk("busy_latency", 32'(n), 32'(35 * d + 1));
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("sclk_timing", 32'(sclk_err), 32'd0);
    chk("mosi_stable", 32'(mosi_err), 32'd0);
    chk("done_at_cs_rise", 32'(done_err), 32'd0);
    if (hold) begin
      start_r = 1'b0;
      tick();
      chk("no_requeue", 32'(o_busy), 32'd0);
    end
  endtask

  function automatic logic [15:0] model_mosi(input logic [7:0] c, input logic [7:0] w);
    return c[7] ? {c, 8'h00} : {c, w};
  endfunction

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  wdata;
    logic [7:0]  sb;
    logic [15:0] exp_mosi;
    logic [7:0]  exp_rd;
    bit          b2b;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [7:0] model_rd, c, w, sb;
    int n;

    tbl[0] = '{cmd: 8'h05, wdata: 8'hA5, sb: 8'hFF, exp_mosi: 16'h05A5, exp_rd: 8'h00, b2b: 1'b0};
    tbl[1] = '{cmd: 8'h85, wdata: 8'hEE, sb: 8'h3C, exp_mosi: 16'h8500, exp_rd: 8'h3C, b2b: 1'b1};
    tbl[2] = '{cmd: 8'h12, wdata: 8'h34, sb: 8'h99, exp_mosi: 16'h1234, exp_rd: 8'h3C, b2b: 1'b1};
    tbl[3] = '{cmd: 8'hC7, wdata: 8'h11, sb: 8'h5A, exp_mosi: 16'hC700, exp_rd: 8'h5A, b2b: 1'b1};

    sel = 1'b0; start_r = 1'b0; cmd_r = 8'h00; wdata_r = 8'h00; rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_sclk", 32'(o_sclk), 32'd0);
    chk("rst_cs_n", 32'(o_cs_n), 32'd1);
    chk("rst_mosi", 32'(o_mosi), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_rdata", 32'(o_rdata), 32'd0);

    // Directed vectors, run back to back
    for (int i = 0; i < 4; i++) begin
      run_txn(tbl[i].cmd, tbl[i].wdata, tbl[i].sb, tbl[i].exp_mosi, tbl[i].exp_rd, tbl[i].b2b, 1'b0);
    end

    // Randomized transactions against the reference model
    model_rd = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      c  = 8'($urandom);
      w  = 8'($urandom);
      sb = 8'($urandom);
      if (c[7]) model_rd = sb;
      run_txn(c, w, sb, model_mosi(c, w), model_rd, 1'b1, 1'b0);
    end

    // start held high through the transfer, cmd/wdata changed mid-transfer
    repeat (3) tick();
    run_txn(8'h3C, 8'h96, 8'h00, 16'h3C96, model_rd, 1'b0, 1'b1);

    // Make rdata non-zero, then reset during bit 10 of a read
    repeat (2) tick();
    run_txn(8'hA0, 8'h00, 8'h6D, 16'hA000, 8'h6D, 1'b0, 1'b0);
    repeat (2) tick();
    slave_byte = 8'hE7;
    cmd_r      = 8'h9A;
    wdata_r    = 8'h00;
    start_r    = 1'b1;
    tick();
    start_r = 1'b0;
    n = 0;
    while (rises < 11 && n < 200) begin
      tick();
      n++;
    end
    chk("reach_bit10", 32'(rises), 32'd11);
    rst_n    = 1'b0;
    done_cnt = 0;
    tick();
    chk("mid_rst_cs_n", 32'(o_cs_n), 32'd1);
    chk("mid_rst_sclk", 32'(o_sclk), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_rdata", 32'(o_rdata), 32'd0);
    chk("mid_rst_done", 32'(o_done), 32'd0);
    rst_n = 1'b1;
    repeat (20) tick();
    chk("no_done_after_rst", 32'(done_cnt), 32'd0);
    run_txn(8'h01, 8'hFF, 8'h00, 16'h01FF, 8'h00, 1'b0, 1'b0);

    // CLK_DIV=1 instance
    sel = 1'b1;
    repeat (2) tick();
    chk("div1_idle_cs_n", 32'(o_cs_n), 32'd1);
    chk("div1_idle_rdata", 32'(o_rdata), 32'd0);
    run_txn(8'h80, 8'h00, 8'h81, 16'h8000, 8'h81, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
